ysyx_23060061_mdu_alu: RTL and testbench
========================================

Name: ysyx_23060061_mdu_alu

Overview:
Parametrised multi-cycle execute unit and successor to the combinational integer ALU. It keeps all twelve base ALU operations and adds the RV M-extension multiply/divide group. Operands enter through a valid/ready handshake, and results leave from a registered output with its own valid/ready handshake, so the EXU can stall on long operations.
- Single-cycle ops: 1-cycle latency.
- Multiply/divide: iterative, WIDTH steps.

Parameters:
WIDTH, 32, datapath width in bits (32 or 64 supported).
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/op valid
in_ready  out  1  unit can accept (combinational)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
alu_op  in  5  operation select (encoding below)
flush  in  1  synchronous abort of in-flight op
out_valid  out  1  result valid (registered)
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
busy  out  1  high in BUSY state

Behaviour:
Opcode encoding:
- 0x00 add; 0x01 pass b; 0x02 (a+b)&~1; 0x03 sub; 0x04 sltu; 0x05 slt; 0x06 xor; 0x07 sra; 0x08 or; 0x09 and; 0x0A sll; 0x0B srl.
- 0x10 mul (low WIDTH bits); 0x11 mulh (s×s, high); 0x12 mulhsu (a signed, b unsigned, high); 0x13 mulhu (high).
- 0x14 div; 0x15 divu; 0x16 rem; 0x17 remu.
- Any other code: result 0 with 1-cycle latency.
- slt/sltu results are zero-extended 1/0. All arithmetic wraps modulo 2^WIDTH.

States:
- IDLE, BUSY, DONE.
- Reset (async): state=IDLE, out_valid=0, result=0, busy=0, counter=0, internal accumulators=0.
- A reset asserted mid-operation discards that operation.

Handshake:
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready) || (state==DONE && !out_valid).
- Accept in DONE while the result is consumed is a back-to-back issue. The old result is dropped and the next operation begins the same cycle.
- Result is consumed when out_valid && out_ready. With no new accept, the state goes to IDLE and out_valid=0 next cycle.
- result and out_valid hold stable while out_valid && !out_ready.

Latency, counted from the accept edge as cycle 0:
- Base ops and illegal ops: result registered at accept; out_valid=1 in cycle 1 (state DONE).
- Multiply: operands are captured with sign correction applied (absolute values plus a result-sign flag, per op signedness). Radix-2 shift-add runs for WIDTH cycles in BUSY, producing a 2*WIDTH-bit product. The product is negated if the sign flag is set, and the low or high half is selected. out_valid=1 in cycle WIDTH+1.
- Divide/remainder: restoring division on absolute values for WIDTH cycles in BUSY. The quotient is negated if the operand signs differ (signed ops); the remainder takes the dividend's sign. out_valid=1 in cycle WIDTH+1.

Divide special cases (resolved at accept, 1-cycle latency, no BUSY):
- Divide by zero: quotient = all ones; remainder = a.
- Signed overflow (a = most-negative, b = all ones): quotient = a; remainder = 0.

Flush:
- When flush=1: state goes to IDLE, out_valid=0 and busy=0 next cycle, regardless of state.
- An in_valid in the same cycle as flush is not accepted; in_ready is forced to 0 while flush=1.

Other rules:
- busy=1 exactly during BUSY cycles.
- Operand inputs may change after accept without affecting the in-flight operation.

Test Plan:
- WIDTH=32, add a=0xFFFFFFFF b=2, out_ready=1 -> result 0x00000001, out_valid exactly 1 cycle after accept; sra a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000.
- mulh a=0x80000000 b=0x80000000 -> 0x40000000 with out_valid at cycle 33 and busy high cycles 1-32; mulhsu a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; mul a=7 b=-3 -> 0xFFFFFFEB.
- div a=-7 b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu a=5 b=0 -> 0xFFFFFFFF at cycle 1; rem a=0x80000000 b=0xFFFFFFFF -> 0, div -> 0x80000000 at cycle 1.
- Backpressure: out_ready=0 for 5 cycles after a divu result -> result/out_valid stable and in_ready=0. Then out_ready=1 together with in_valid (xor a=0xF0 b=0xFF) -> back-to-back accept, next result 0x0F one cycle later.
- Flush at BUSY cycle 10 of a mul -> IDLE next cycle, out_valid never asserts. A new add 1+1 issued after the flush returns 2.
- Async rst asserted mid-divide between clock edges -> out_valid=0, result=0, busy=0 immediately; after release, in_ready=1.
- WIDTH=64 instance: sll a=1 b=63 -> 0x8000000000000000; mulhu a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE at cycle 65.

Source files
------------

// File: rtl/ysyx_23060061_mdu_alu.sv
// Multi-cycle execute unit: base integer ALU plus iterative multiply/divide,
// with valid/ready handshakes on both operand input and registered result.
module ysyx_23060061_mdu_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     opnd;
  logic [2:0]           op_q;
  logic                 neg;
  logic [SHAMT_W-1:0]   cnt;

  logic                 fire;
  logic                 is_mul, is_div, sgn_a, sgn_b, neg_start;
  logic                 div_zero, div_ovf, short_op;
  logic [WIDTH-1:0]     a_abs, b_abs, quick_res;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     step_acc, step_lo, q_fin, r_fin, fin_res;
  logic [DW-1:0]        prod, prod_fin;

  // Accept is blocked while flushing and while a result is stuck on backpressure
  assign in_ready = !flush && ((state == IDLE) || (state == DONE && (out_ready || !out_valid)));
  assign fire     = in_valid && in_ready;
  assign shamt    = b[SHAMT_W-1:0];

  // Operand decode: signedness, absolute values, result sign and divide special cases
  always_comb begin
    is_mul    = (alu_op[4:2] == 3'b100);
    is_div    = (alu_op[4:2] == 3'b101);
    sgn_a     = is_mul ? (alu_op[1:0] == 2'b01 || alu_op[1:0] == 2'b10) : (is_div && !alu_op[0]);
    sgn_b     = is_mul ? (alu_op[1:0] == 2'b01) : (is_div && !alu_op[0]);
    a_abs     = (sgn_a && a[WIDTH-1]) ? -a : a;
    b_abs     = (sgn_b && b[WIDTH-1]) ? -b : b;
    // remainder takes the dividend's sign; everything else takes the xor of operand signs
    neg_start = (is_div && alu_op[1]) ? (sgn_a && a[WIDTH-1])
                                      : ((sgn_a && a[WIDTH-1]) ^ (sgn_b && b[WIDTH-1]));
    div_zero  = is_div && (b == '0);
    div_ovf   = is_div && !alu_op[0] && (a == MOST_NEG) && (b == ALL_ONES);
    short_op  = !(is_mul || is_div) || div_zero || div_ovf;
  end

  // Single-cycle results: base ALU ops, illegal codes and divide corner cases
  always_comb begin
    quick_res = '0;
    case (alu_op)
      5'h00: quick_res = a + b;
      5'h01: quick_res = b;
      5'h02: quick_res = (a + b) & ~WIDTH'(1);
      5'h03: quick_res = a - b;
      5'h04: quick_res = WIDTH'(a < b);
      5'h05: quick_res = WIDTH'($signed(a) < $signed(b));
      5'h06: quick_res = a ^ b;
      5'h07: quick_res = $signed(a) >>> shamt;
      5'h08: quick_res = a | b;
      5'h09: quick_res = a & b;
      5'h0A: quick_res = a << shamt;
      5'h0B: quick_res = a >> shamt;
      default: quick_res = '0;
    endcase
    if (div_zero)
      quick_res = alu_op[1] ? a : ALL_ONES;
    else if (div_ovf)
      quick_res = alu_op[1] ? '0 : a;
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = !div_diff[WIDTH];
    if (!op_q[2]) begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      step_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo  = {lo[WIDTH-2:0], div_ge};
    end
    prod     = {step_acc, step_lo};
    prod_fin = neg ? -prod : prod;
    q_fin    = neg ? -step_lo : step_lo;
    r_fin    = neg ? -step_acc : step_acc;
    if (!op_q[2])
      fin_res = (op_q[1:0] == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[DW-1:WIDTH];
    else
      fin_res = op_q[1] ? r_fin : q_fin;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      lo        <= '0;
      opnd      <= '0;
      op_q      <= '0;
      neg       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (fire) begin
      op_q <= alu_op[2:0];
      if (short_op) begin
        result    <= quick_res;
        out_valid <= 1'b1;
        busy      <= 1'b0;
        state     <= DONE;
      end else begin
        acc       <= '0;
        lo        <= is_mul ? b_abs : a_abs;
        opnd      <= is_mul ? a_abs : b_abs;
        neg       <= neg_start;
        cnt       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b1;
        state     <= BUSY;
      end
    end else begin
      case (state)
        BUSY: begin
          acc <= step_acc;
          lo  <= step_lo;
          cnt <= cnt + SHAMT_W'(1);
          if (cnt == SHAMT_W'(WIDTH - 1)) begin
            result    <= fin_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mdu_alu.sv
// Directed bench for the multi-cycle ALU/MDU at WIDTH=32 and WIDTH=64.
module tb_ysyx_23060061_mdu_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  logic [4:0]  alu_op;

  logic        w_in_valid, w_in_ready, w_out_valid, w_busy;
  logic [63:0] w_a, w_b, w_result;
  logic [4:0]  w_alu_op;

  int n_chk  = 0;
  int n_fail = 0;

  ysyx_23060061_mdu_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  ysyx_23060061_mdu_alu #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .alu_op(w_alu_op), .flush(flush), .out_valid(w_out_valid),
    .out_ready(out_ready), .result(w_result), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles from the accept edge until out_valid
  task automatic run(input bit w, input logic [4:0] op, input logic [63:0] av, input logic [63:0] bv,
                     output logic [63:0] res, output int lat, output int nb);
    @(negedge clk);
    if (w) begin w_alu_op = op; w_a = av; w_b = bv; w_in_valid = 1'b1; end
    else begin alu_op = op; a = av[31:0]; b = bv[31:0]; in_valid = 1'b1; end
    @(posedge clk);
    #1;
    in_valid = 1'b0; w_in_valid = 1'b0;
    a = $urandom; b = $urandom; w_a = {$urandom, $urandom}; w_b = {$urandom, $urandom};
    lat = -1; nb = 0; res = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (w ? w_out_valid : out_valid) begin
        lat = c;
        res = w ? w_result : {32'h0, result};
        break;
      end
      if (w ? w_busy : busy) nb++;
    end
  endtask

  task automatic op_chk(input string tag, input bit w, input logic [4:0] op,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat, nb;
    run(w, op, av, bv, res, lat, nb);
    chk(tag, res, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(nb), 64'(exp_lat - 1));
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; alu_op = '0;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_alu_op = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // base ops
    op_chk("add_wrap", 0, 5'h00, 64'hFFFFFFFF, 64'd2, 64'h1, 1);
    op_chk("sra", 0, 5'h07, 64'h80000000, 64'h24, 64'hF8000000, 1);
    op_chk("slt", 0, 5'h05, 64'hFFFFFFFF, 64'd1, 64'd1, 1);
    op_chk("sltu", 0, 5'h04, 64'hFFFFFFFF, 64'd1, 64'd0, 1);
    op_chk("sub", 0, 5'h03, 64'd5, 64'd7, 64'hFFFFFFFE, 1);
    op_chk("addmask", 0, 5'h02, 64'd7, 64'd2, 64'd8, 1);
    op_chk("illegal", 0, 5'h1F, 64'h1234, 64'h5678, 64'd0, 1);

    // multiply
    op_chk("mulh", 0, 5'h11, 64'h80000000, 64'h80000000, 64'h40000000, 33);
    op_chk("mulhsu", 0, 5'h12, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33);
    op_chk("mul", 0, 5'h10, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 33);
    op_chk("mulhu", 0, 5'h13, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);

    // divide
    op_chk("div_neg", 0, 5'h14, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33);
    op_chk("rem_neg", 0, 5'h16, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33);
    op_chk("div_negb", 0, 5'h14, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD, 33);
    op_chk("rem_negb", 0, 5'h16, 64'd7, 64'hFFFFFFFE, 64'd1, 33);
    op_chk("remu", 0, 5'h17, 64'd100, 64'd7, 64'd2, 33);
    op_chk("divu_zero", 0, 5'h15, 64'd5, 64'd0, 64'hFFFFFFFF, 1);
    op_chk("rem_zero", 0, 5'h16, 64'd5, 64'd0, 64'd5, 1);
    op_chk("rem_ovf", 0, 5'h16, 64'h80000000, 64'hFFFFFFFF, 64'd0, 1);
    op_chk("div_ovf", 0, 5'h14, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);

    // backpressure then back-to-back issue
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 5'h15; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !out_valid; c++) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_valid_arrives", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_result", 64'(result), 64'd14);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    alu_op = 5'h06; a = 32'hF0; b = 32'hFF; in_valid = 1'b1;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_result", 64'(result), 64'h0F);

    // flush blocks accept while idle
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;

    // flush at busy cycle 10 of a multiply
    alu_op = 5'h10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_valid_after", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    op_chk("add_after_flush", 0, 5'h00, 64'd1, 64'd1, 64'd2, 1);

    // async reset in the middle of a divide
    @(negedge clk);
    alu_op = 5'h14; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_in_ready", 64'(in_ready), 64'd1);

    // 64-bit instance
    op_chk("w64_sll", 1, 5'h0A, 64'd1, 64'd63, 64'h8000000000000000, 1);
    op_chk("w64_mulhu", 1, 5'h13, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
